// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions imported by the ALU, the decoder control and the
// ALU arbiter.
//   XLEN_DEFAULT      : default operand/result width
//   alu_ctrl_e        : the ten legal 4-bit alu_ctrl encodings
//   is_legal_alu_ctrl : 1 when a raw 4-bit code is one of alu_ctrl_e
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_SRA  = 4'b1101
   } alu_ctrl_e;

   function automatic logic is_legal_alu_ctrl(input logic [3:0] code);
      logic legal;
      legal = 1'b0;
      case (code)
         ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
         ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: legal = 1'b1;
         default:                                    legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Request and response handshake bundle between the ALU requesters and the
// ALU arbiter.
//   req_valid/req_ready : per-requester valid/ready (ready at most one-hot)
//   req_op/req_a/req_b  : per-requester alu_ctrl code and operands
//   resp_valid/ready    : response handshake to the single consumer
//   resp_id/result/err  : requester index, captured result, illegal-op flag
// Modports: master = requester/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_arbiter_if
   import alu_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) ();

   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ-1:0]           req_ready;
   logic [N_REQ-1:0][3:0]      req_op;
   logic [N_REQ-1:0][XLEN-1:0] req_a;
   logic [N_REQ-1:0][XLEN-1:0] req_b;

   logic                       resp_valid;
   logic                       resp_ready;
   logic [ID_W-1:0]            resp_id;
   logic [XLEN-1:0]            resp_result;
   logic                       resp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_result, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_id, resp_result, resp_err
   );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at ptr_i and wraps
// modulo N_REQ; the first requesting index found wins.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle (must be < N_REQ)
//   en_i    : grant enable; when low grant_o is all-zero
//   grant_o : one-hot grant (gated by en_i)
//   idx_o   : winning index (valid when any_o=1, independent of en_i)
//   any_o   : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   input  logic             en_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int unsigned cand;

   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         // ptr_i < N_REQ, so one conditional subtract implements the wrap
         cand = 32'(ptr_i) + off;
         if (cand >= 32'(N_REQ)) begin
            cand = cand - 32'(N_REQ);
         end
         if (!any_o && req_i[IDX_W'(cand)]) begin
            any_o = 1'b1;
            idx_o = IDX_W'(cand);
         end
      end
   end

   always_comb begin
      grant_o = '0;
      if (any_o && en_i) begin
         grant_o[idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between N_REQ requesters. A
// round-robin pick is registered into an issue stage that drives the ALU;
// the ALU result is captured into a response register tagged with the
// requester index. Illegal op codes return result 0 with resp_err=1.
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : request/response handshakes (alu_arbiter_if)
//   alu_ctrl_o/a_o/b_o : issue-stage op and operands to the ALU (0 when idle)
//   alu_result_i       : combinational ALU result
// ---------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_arbiter_if.slave    bus,
   output logic [3:0]      alu_ctrl_o,
   output logic [XLEN-1:0] alu_a_o,
   output logic [XLEN-1:0] alu_b_o,
   input  logic [XLEN-1:0] alu_result_i
);

   // issue stage
   logic            iss_v_q,  iss_v_d;
   logic [ID_W-1:0] iss_id_q, iss_id_d;
   logic [3:0]      iss_op_q, iss_op_d;
   logic [XLEN-1:0] iss_a_q,  iss_a_d;
   logic [XLEN-1:0] iss_b_q,  iss_b_d;

   // response stage
   logic            resp_valid_q,  resp_valid_d;
   logic [ID_W-1:0] resp_id_q,     resp_id_d;
   logic [XLEN-1:0] resp_result_q, resp_result_d;
   logic            resp_err_q,    resp_err_d;

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             resp_adv;
   logic             can_accept;
   logic             accept;
   logic             op_legal;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  gnt_idx;
   logic             gnt_any;

   assign resp_adv   = iss_v_q & (~resp_valid_q | bus.resp_ready);
   assign can_accept = ~iss_v_q | resp_adv;
   assign accept     = can_accept & gnt_any;
   assign op_legal   = is_legal_alu_ctrl(iss_op_q);

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (ID_W)
   ) u_rr_arbiter (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .en_i    (can_accept),
      .grant_o (grant),
      .idx_o   (gnt_idx),
      .any_o   (gnt_any)
   );

   assign bus.req_ready = grant;

   always_comb begin
      iss_v_d  = iss_v_q;
      iss_id_d = iss_id_q;
      iss_op_d = iss_op_q;
      iss_a_d  = iss_a_q;
      iss_b_d  = iss_b_q;
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         iss_v_d  = 1'b1;
         iss_id_d = gnt_idx;
         iss_op_d = bus.req_op[gnt_idx];
         iss_a_d  = bus.req_a[gnt_idx];
         iss_b_d  = bus.req_b[gnt_idx];
         rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (resp_adv) begin
         iss_v_d  = 1'b0;
      end
   end

   always_comb begin
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      resp_err_d    = resp_err_q;
      if (resp_adv) begin
         resp_valid_d  = 1'b1;
         resp_id_d     = iss_id_q;
         resp_result_d = op_legal ? alu_result_i : '0;
         resp_err_d    = ~op_legal;
      end else if (bus.resp_ready) begin
         resp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_v_q       <= 1'b0;
         iss_id_q      <= '0;
         iss_op_q      <= '0;
         iss_a_q       <= '0;
         iss_b_q       <= '0;
         rr_ptr_q      <= '0;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= '0;
         resp_result_q <= '0;
         resp_err_q    <= 1'b0;
      end else begin
         iss_v_q       <= iss_v_d;
         iss_id_q      <= iss_id_d;
         iss_op_q      <= iss_op_d;
         iss_a_q       <= iss_a_d;
         iss_b_q       <= iss_b_d;
         rr_ptr_q      <= rr_ptr_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_err_q    <= resp_err_d;
      end
   end

   // idle issue stage presents ADD 0+0 so the ALU inputs stay quiet
   assign alu_ctrl_o = iss_v_q ? iss_op_q : '0;
   assign alu_a_o    = iss_v_q ? iss_a_q  : '0;
   assign alu_b_o    = iss_v_q ? iss_b_q  : '0;

   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_id     = resp_id_q;
   assign bus.resp_result = resp_result_q;
   assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter (N_REQ=2, XLEN=32). Provides a
// behavioural ALU on the alu_* ports, a table of single-op vectors with
// hand-computed results, and multi-cycle sequences for contention,
// backpressure and mid-flight reset. A scoreboard queue records the
// expected response at each observed request handshake and checks it on
// each response handshake.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

   localparam int N  = 2;
   localparam int XL = 32;

   typedef struct {
      logic        id;
      logic [31:0] res;
      logic        err;
   } exp_t;

   typedef struct {
      logic        rq;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        err;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;

   int          n_assert;
   int          n_fail;
   exp_t        sb[$];
   logic [1:0]  glog[$];

   alu_arbiter_if #(.N_REQ(N), .XLEN(XL)) bus ();

   alu_arbiter #(.N_REQ(N), .XLEN(XL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .alu_ctrl_o   (alu_ctrl),
      .alu_a_o      (alu_a),
      .alu_b_o      (alu_b),
      .alu_result_i (alu_result)
   );

   function automatic logic ref_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

   // illegal codes yield a nonzero pattern so result zeroing is visible
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << b[4:0];
         4'b0010: return {31'd0, $signed(a) < $signed(b)};
         4'b0011: return {31'd0, a < b};
         4'b0100: return a ^ b;
         4'b0101: return a >> b[4:0];
         4'b1101: return $unsigned($signed(a) >>> b[4:0]);
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic vec_t mkv(input logic rq, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] res, input logic err);
      vec_t v;
      v.rq = rq; v.op = op; v.a = a; v.b = b; v.res = res; v.err = err;
      return v;
   endfunction

   always_comb alu_result = ref_alu(alu_ctrl, alu_a, alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
            for (int unsigned i = 0; i < N; i++) begin
               if (bus.req_valid[1'(i)] && bus.req_ready[1'(i)]) begin
                  e.id  = 1'(i);
                  e.err = !ref_legal(bus.req_op[1'(i)]);
                  e.res = e.err ? 32'd0 : ref_alu(bus.req_op[1'(i)], bus.req_a[1'(i)], bus.req_b[1'(i)]);
                  sb.push_back(e);
               end
            end
            if (bus.resp_valid && bus.resp_ready) begin
               if (sb.size() == 0) begin
                  chk("sb_unexpected_resp", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("sb_id",     32'(bus.resp_id),  32'(e.id));
                  chk("sb_result", bus.resp_result,   e.res);
                  chk("sb_err",    32'(bus.resp_err), 32'(e.err));
               end
            end
         end
      end
   endtask

   // Entered and left at posedge+1. Requester i stays valid until c_i
   // handshakes; resp_ready is low for the first 'stall' cycles.
   task automatic burst(input int c0, input int c1, input int stall,
                        output int acc_st, output logic [1:0] rdy_last, output logic held_v,
                        output logic [31:0] held_res, output logic held_id, output int post);
      int         rem0, rem1, cyc;
      logic [1:0] rdy;
      rem0 = c0; rem1 = c1; cyc = 0;
      acc_st = 0; post = 0; rdy_last = '0; held_v = 1'b0; held_res = '0; held_id = 1'b0;
      forever begin
         bus.req_valid  = {rem1 > 0, rem0 > 0};
         bus.resp_ready = (cyc >= stall);
         @(negedge clk);
         rdy = bus.req_ready;
         if (rdy != 2'b00) glog.push_back(rdy);
         if (cyc < stall) begin
            if (rdy != 2'b00) acc_st++;
            if (cyc == stall - 1) begin
               rdy_last = rdy;
               held_v   = bus.resp_valid;
               held_res = bus.resp_result;
               held_id  = bus.resp_id;
            end
         end else begin
            post++;
         end
         if (bus.req_valid[0] && rdy[0]) rem0--;
         if (bus.req_valid[1] && rdy[1]) rem1--;
         @(posedge clk); #1;
         cyc++;
         if (rem0 == 0 && rem1 == 0 && sb.size() == 0) break;
         if (cyc > 200) begin
            chk("burst_timeout", 32'd1, 32'd0);
            break;
         end
      end
      bus.req_valid  = '0;
      bus.resp_ready = 1'b1;
   endtask

   task automatic run_single(input vec_t v, input int k);
      bus.req_valid       = 2'b01 << v.rq;
      bus.req_op[v.rq]    = v.op;
      bus.req_a[v.rq]     = v.a;
      bus.req_b[v.rq]     = v.b;
      @(negedge clk);
      chk($sformatf("v%0d_ready", k), 32'(bus.req_ready), 32'(2'b01 << v.rq));
      @(posedge clk); #1;
      bus.req_valid = '0;
      @(negedge clk);
      chk($sformatf("v%0d_resp_v_early", k), 32'(bus.resp_valid), 32'd0);
      chk($sformatf("v%0d_alu_ctrl", k), 32'(alu_ctrl), 32'(v.op));
      chk($sformatf("v%0d_alu_a", k), alu_a, v.a);
      chk($sformatf("v%0d_alu_b", k), alu_b, v.b);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("v%0d_resp_v", k), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("v%0d_id", k), 32'(bus.resp_id), 32'(v.rq));
      chk($sformatf("v%0d_result", k), bus.resp_result, v.res);
      chk($sformatf("v%0d_err", k), 32'(bus.resp_err), 32'(v.err));
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t        tv[13];
      int          acc_st, post;
      logic [1:0]  rdy_last;
      logic        held_v, held_id;
      logic [31:0] held_res;

      tv[0]  = mkv(1'b0, 4'b0000, 32'd5,          32'd7,          32'd12,         1'b0);
      tv[1]  = mkv(1'b1, 4'b1000, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0);
      tv[2]  = mkv(1'b0, 4'b1101, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0);
      tv[3]  = mkv(1'b1, 4'b0001, 32'd1,          32'd31,         32'h8000_0000,  1'b0);
      tv[4]  = mkv(1'b0, 4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0);
      tv[5]  = mkv(1'b1, 4'b0011, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);
      tv[6]  = mkv(1'b0, 4'b0100, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0);
      tv[7]  = mkv(1'b1, 4'b0101, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0);
      tv[8]  = mkv(1'b0, 4'b0110, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0);
      tv[9]  = mkv(1'b1, 4'b0111, 32'h0000_0F0F,  32'h0000_00FF,  32'h0000_000F,  1'b0);
      tv[10] = mkv(1'b1, 4'b1001, 32'd1,          32'd1,          32'd0,          1'b1);
      tv[11] = mkv(1'b1, 4'b0011, 32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0);
      tv[12] = mkv(1'b0, 4'b1111, 32'd2,          32'd3,          32'd0,          1'b1);

      n_assert = 0;
      n_fail   = 0;
      rst_n          = 1'b0;
      bus.req_valid  = '0;
      bus.req_op     = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b1;
      fork
         monitor();
      join_none

      // reset values
      #2;
      chk("rst_resp_valid",  32'(bus.resp_valid), 32'd0);
      chk("rst_resp_id",     32'(bus.resp_id),    32'd0);
      chk("rst_resp_result", bus.resp_result,     32'd0);
      chk("rst_resp_err",    32'(bus.resp_err),   32'd0);
      chk("rst_alu_ctrl",    32'(alu_ctrl),       32'd0);
      chk("rst_alu_a",       alu_a,               32'd0);
      chk("rst_alu_b",       alu_b,               32'd0);
      bus.req_valid = 2'b10;
      #1;
      chk("rst_ready_single", 32'(bus.req_ready), 32'd2);
      bus.req_valid = '0;
      #10;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // contention from reset: grants alternate 0,1,0,1 at one op per cycle
      bus.req_op[0] = 4'b1101; bus.req_a[0] = 32'h8000_0000; bus.req_b[0] = 32'd4;
      bus.req_op[1] = 4'b1000; bus.req_a[1] = 32'd3;         bus.req_b[1] = 32'd5;
      glog.delete();
      burst(2, 2, 0, acc_st, rdy_last, held_v, held_res, held_id, post);
      chk("cont_grants", 32'(glog.size()), 32'd4);
      if (glog.size() == 4) begin
         chk("cont_g0", 32'(glog[0]), 32'd1);
         chk("cont_g1", 32'(glog[1]), 32'd2);
         chk("cont_g2", 32'(glog[2]), 32'd1);
         chk("cont_g3", 32'(glog[3]), 32'd2);
      end
      chk("cont_cycles", 32'(post), 32'd6);

      // single-op vectors
      for (int k = 0; k < 13; k++) begin
         run_single(tv[k], k);
      end

      // backpressure: last vector used requester 0, so requester 1 goes first
      bus.req_op[0] = 4'b0000; bus.req_a[0] = 32'd1;    bus.req_b[0] = 32'd2;
      bus.req_op[1] = 4'b0100; bus.req_a[1] = 32'hFF;   bus.req_b[1] = 32'h0F;
      burst(3, 3, 5, acc_st, rdy_last, held_v, held_res, held_id, post);
      chk("bp_accepts",    32'(acc_st),   32'd2);
      chk("bp_ready_full", 32'(rdy_last), 32'd0);
      chk("bp_held_valid", 32'(held_v),   32'd1);
      chk("bp_held_id",    32'(held_id),  32'd1);
      chk("bp_held_res",   held_res,      32'h0000_00F0);
      chk("bp_drain",      32'(post),     32'd6);

      // reset with both pipeline stages occupied
      bus.req_op[0] = 4'b0110; bus.req_a[0] = 32'h11; bus.req_b[0] = 32'h22;
      bus.req_op[1] = 4'b0110; bus.req_a[1] = 32'h33; bus.req_b[1] = 32'h44;
      bus.req_valid  = 2'b11;
      bus.resp_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("pre_rst_alu_ctrl",   32'(alu_ctrl),       32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("mid_rst_resp_valid",  32'(bus.resp_valid), 32'd0);
      chk("mid_rst_resp_id",     32'(bus.resp_id),    32'd0);
      chk("mid_rst_resp_result", bus.resp_result,     32'd0);
      chk("mid_rst_resp_err",    32'(bus.resp_err),   32'd0);
      chk("mid_rst_alu_ctrl",    32'(alu_ctrl),       32'd0);
      chk("mid_rst_alu_a",       alu_a,               32'd0);
      chk("mid_rst_alu_b",       alu_b,               32'd0);
      chk("mid_rst_ready",       32'(bus.req_ready),  32'd1);
      bus.req_valid  = '0;
      bus.resp_ready = 1'b1;
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post_rst_idle%0d", k), 32'(bus.resp_valid), 32'd0);
         @(posedge clk); #1;
      end
      bus.req_op[0] = 4'b0000; bus.req_a[0] = 32'd100; bus.req_b[0] = 32'd1;
      bus.req_op[1] = 4'b0000; bus.req_a[1] = 32'd200; bus.req_b[1] = 32'd2;
      glog.delete();
      burst(1, 1, 0, acc_st, rdy_last, held_v, held_res, held_id, post);
      if (glog.size() > 0) chk("post_rst_first_grant", 32'(glog[0]), 32'd1);
      else                 chk("post_rst_no_grant", 32'd0, 32'd1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the core's single combinational ALU between N_REQ requesters (execute stage, branch-compare unit, load/store address generator) over valid/ready handshakes. Round-robin arbitration picks one request per cycle, registers it into an issue stage that drives the ALU, and captures the result into a response register tagged with the requester ID. The ALU stays outside this block: the arbiter only sequences it.

## Interface
- N_REQ, default 2: number of requesters (2..4).
- XLEN, default 32: operand and result width.
- ID_W, default $clog2(N_REQ): requester ID width (minimum 1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_op  in  N_REQ×4  per-requester alu_ctrl code.
- req_a, req_b  in  N_REQ×XLEN  per-requester operands.
- alu_ctrl_o  out  4  to ALU: issue-stage op.
- alu_a_o, alu_b_o  out  XLEN  to ALU: issue-stage operands.
- alu_result_i  in  XLEN  from ALU: combinational result.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept (single consumer side).
- resp_id  out  ID_W  requester index of the response.
- resp_result  out  XLEN  captured result.
- resp_err  out  1  op code was not a legal alu_ctrl value.

## Operation
- Legal codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111. Any other code is illegal.
- Two-stage pipeline: issue register (iss_v, id, op, a, b) and response register (resp_valid, id, result, err).
- Advance conditions:
  - resp_adv = iss_v & (~resp_valid | resp_ready).
  - can_accept = ~iss_v | resp_adv.
- Arbitration is combinational round-robin over req_valid. The search starts at rr_ptr and wraps modulo N_REQ. req_ready[g] = can_accept for the granted index g only.
- On acceptance, the issue register loads the request and rr_ptr becomes (g+1) mod N_REQ. rr_ptr does not change without an acceptance.
- alu_ctrl_o, alu_a_o and alu_b_o always reflect the issue register. When iss_v=0 they are forced to 0 (ADD 0+0) to limit toggling.
- On resp_adv, the response register captures:
  - resp_result = alu_result_i, or 0 if the op is illegal;
  - resp_err = illegal-op flag;
  - resp_id = issue id.
- resp_valid falls on resp_ready only when no new result is being captured in the same cycle.
- Response fields are held stable while resp_valid=1 and resp_ready=0.
- A request, once valid, must not be withdrawn or changed by the requester until it is accepted. The arbiter does not check this.

## Timing
- Reset values: iss_v=0, rr_ptr=0, resp_valid=0, resp_id=0, resp_result=0, resp_err=0, alu_* outputs=0, req_ready follows can_accept=1 combinationally.
- Latency: a request accepted at edge E presents to the ALU in cycle E..E+1, and resp_valid is high after edge E+1, i.e. 2 cycles.
- Throughput: 1 op per cycle while resp_ready=1.
- Full pipeline (iss_v=1, resp_valid=1, resp_ready=0): all req_ready=0. Nothing is lost or overwritten.
- Simultaneous drain and refill: in the same edge the response register takes the issue entry and the issue register takes a new request, so there is no bubble.
- Simultaneous requests: only the requester nearest rr_ptr is granted; the others stall with req_ready=0.
- Single requester: it is granted every cycle regardless of rr_ptr.
- Reset mid-operation: in-flight issue and response entries are discarded immediately, asynchronously. No response is ever produced for them.

## Structure
- alu_pkg holds:
  - the alu_ctrl_e enum of the ten legal codes;
  - function is_legal_alu_ctrl();
  - localparam XLEN_DEFAULT = 32.
  The ALU, decoder control and this block all import it.
- Natural sub-module: rr_arbiter. It is parameterised N_REQ and takes req, ptr, en, returning a one-hot grant and the index. It is reused later by the register-file port arbiter.
- The remainder stays in alu_arbiter: the issue and response registers and the advance logic.

## Test plan
- Single op: requester 0 sends ADD, a=5, b=7, with resp_ready=1 → req_ready[0]=1 for one cycle; two cycles later resp_valid=1, resp_id=0, resp_result=12, resp_err=0.
- Contention: both requesters valid every cycle from reset, resp_ready=1 → grants alternate 0,1,0,1. Requester 1 sends SUB 3−5 → result 0xFFFFFFFE; requester 0 sends SRA 0x80000000>>4 → 0xF8000000.
- Backpressure: hold resp_ready=0 for 5 cycles with requests pending → after 2 accepts, req_ready=0 and the response is held stable. Releasing resp_ready gives back-to-back responses in order with no loss.
- Illegal op: code 1001, a=1, b=1 → resp_err=1, resp_result=0. The next legal op (SLTU 1<0xFFFFFFFF) returns 1 with err=0.
- Reset mid-flight: assert rst_n=0 while iss_v=1 and resp_valid=1 → all outputs reach their reset values without waiting for a clock edge. After release, rr_ptr=0 and no stale response appears.
